// File: rtl/byte_unstriping_pkg.sv
// Shared constants and FSM encoding for the lane striper/unstriper pair.
package byte_unstriping_pkg;

   localparam int VALID_BIT = 8;
   localparam int WORD_W    = VALID_BIT + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EMIT0 = 2'd1,
      ST_EMIT1 = 2'd2
   } state_t;

endpackage

// File: rtl/byte_unstriping.sv
// Merges two half-rate lanes back into one full-rate byte stream, flagging
// order and strobe-spacing violations and counting delivered words.
module byte_unstriping
   import byte_unstriping_pkg::*;
#(
   parameter int WIDTH   = VALID_BIT,
   parameter int COUNT_W = 16
) (
   input  logic               clk2f,
   input  logic               reset_L,
   input  logic               lane_strobe,
   input  logic [WIDTH:0]     lane0,
   input  logic [WIDTH:0]     lane1,
   output logic [WIDTH:0]     dataout0,
   output logic               active,
   output logic               err_order,
   output logic               err_strobe,
   output logic [COUNT_W-1:0] word_count
);

   state_t               state_r;
   state_t               state_nxt_s;
   logic [WIDTH:0]       hold0_r;
   logic [WIDTH:0]       hold1_r;
   logic [WIDTH:0]       dataout0_r;
   logic                 active_r;
   logic                 err_order_r;
   logic                 err_strobe_r;
   logic [COUNT_W-1:0]   word_count_r;

   logic                 strobe_go_s;
   logic                 strobe_bad_s;
   logic                 load_s;
   logic [WIDTH:0]       out_nxt_s;
   logic                 err_order_nxt_s;
   logic                 err_strobe_nxt_s;

   assign strobe_go_s  = lane_strobe & lane0[WIDTH];
   assign strobe_bad_s = lane_strobe & ~lane0[WIDTH] & lane1[WIDTH];

   // State register; active mirrors the state it is updated with.
   always_ff @(posedge clk2f or negedge reset_L) begin
      if (!reset_L) begin
         state_r  <= ST_IDLE;
         active_r <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         active_r <= (state_nxt_s != ST_IDLE);
      end
   end

   // Next-state decode.
   always_comb begin
      state_nxt_s = ST_IDLE;
      case (state_r)
         ST_IDLE: begin
            if (strobe_go_s) begin
               state_nxt_s = ST_EMIT0;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_EMIT0: state_nxt_s = ST_EMIT1;
         ST_EMIT1: begin
            if (strobe_go_s) begin
               state_nxt_s = ST_EMIT0;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Output decode: next stream word, hold load and error pulses.
   always_comb begin
      out_nxt_s        = {(WIDTH+1){1'b0}};
      load_s           = 1'b0;
      err_order_nxt_s  = 1'b0;
      err_strobe_nxt_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            load_s          = strobe_go_s;
            err_order_nxt_s = strobe_bad_s;
         end
         ST_EMIT0: begin
            out_nxt_s        = hold0_r;
            err_strobe_nxt_s = lane_strobe;
         end
         ST_EMIT1: begin
            // An invalid second byte marks an odd-length tail: emit idle.
            if (hold1_r[WIDTH]) begin
               out_nxt_s = hold1_r;
            end else begin
               out_nxt_s = {(WIDTH+1){1'b0}};
            end
            load_s          = strobe_go_s;
            err_order_nxt_s = strobe_bad_s;
         end
         default: begin
            out_nxt_s = {(WIDTH+1){1'b0}};
         end
      endcase
   end

   // Holding registers, stream output, error pulses and saturating word count.
   always_ff @(posedge clk2f or negedge reset_L) begin
      if (!reset_L) begin
         hold0_r      <= {(WIDTH+1){1'b0}};
         hold1_r      <= {(WIDTH+1){1'b0}};
         dataout0_r   <= {(WIDTH+1){1'b0}};
         err_order_r  <= 1'b0;
         err_strobe_r <= 1'b0;
         word_count_r <= {COUNT_W{1'b0}};
      end else begin
         if (load_s) begin
            hold0_r <= lane0;
            hold1_r <= lane1;
         end
         dataout0_r   <= out_nxt_s;
         err_order_r  <= err_order_nxt_s;
         err_strobe_r <= err_strobe_nxt_s;
         if (out_nxt_s[WIDTH] && (word_count_r != {COUNT_W{1'b1}})) begin
            word_count_r <= word_count_r + {{(COUNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign dataout0   = dataout0_r;
   assign active     = active_r;
   assign err_order  = err_order_r;
   assign err_strobe = err_strobe_r;
   assign word_count = word_count_r;

endmodule

// File: tb/tb_byte_unstriping.sv
// Scoreboard bench for byte_unstriping: expected words queued at drive time,
// popped by a monitor whenever the merged stream carries a valid word.
module tb_byte_unstriping;
   import byte_unstriping_pkg::*;

   localparam int W  = WORD_W;
   localparam int CW = 16;

   logic          clk2f       = 1'b0;
   logic          reset_L     = 1'b1;
   logic          lane_strobe = 1'b0;
   logic [W-1:0]  lane0       = '0;
   logic [W-1:0]  lane1       = '0;
   logic [W-1:0]  dataout0;
   logic          active;
   logic          err_order;
   logic          err_strobe;
   logic [CW-1:0] word_count;

   byte_unstriping #(.WIDTH(W-1), .COUNT_W(CW)) dut (
      .clk2f      (clk2f),
      .reset_L    (reset_L),
      .lane_strobe(lane_strobe),
      .lane0      (lane0),
      .lane1      (lane1),
      .dataout0   (dataout0),
      .active     (active),
      .err_order  (err_order),
      .err_strobe (err_strobe),
      .word_count (word_count)
   );

   always #5 clk2f = ~clk2f;

   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_w;
   int           wc_exp = 0;

   int act_cnt, act_run, act_run_max;
   int val_cnt, val_run, val_run_max;
   int eo_cnt, es_cnt, nz_cnt;

   // Scoreboard monitor: every valid output word must match the next queued word.
   always @(negedge clk2f) begin
      if (dataout0[W-1] === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word: got %h, required no word", dataout0);
         end else begin
            exp_w = exp_q.pop_front();
            if (dataout0 !== exp_w) begin
               errors++;
               $display("FAIL stream_word: got %h, required %h", dataout0, exp_w);
            end
         end
      end
   end

   task automatic clear_stats();
      act_cnt = 0; act_run = 0; act_run_max = 0;
      val_cnt = 0; val_run = 0; val_run_max = 0;
      eo_cnt = 0; es_cnt = 0; nz_cnt = 0;
   endtask

   // One clock: strobe is dropped after the edge, outputs sampled on the falling edge.
   task automatic step();
      @(posedge clk2f);
      #1;
      lane_strobe = 1'b0;
      @(negedge clk2f);
      if (active) begin
         act_cnt++; act_run++;
         if (act_run > act_run_max) act_run_max = act_run;
      end else begin
         act_run = 0;
      end
      if (dataout0[W-1]) begin
         val_cnt++; val_run++;
         if (val_run > val_run_max) val_run_max = val_run;
      end else begin
         val_run = 0;
         if (dataout0 != '0) nz_cnt++;
      end
      if (err_order)  eo_cnt++;
      if (err_strobe) es_cnt++;
   endtask

   task automatic send(input logic [W-1:0] l0, input logic [W-1:0] l1, input bit accept);
      lane0 = l0;
      lane1 = l1;
      lane_strobe = 1'b1;
      if (accept) begin
         exp_q.push_back(l0);
         wc_exp++;
         if (l1[W-1]) begin
            exp_q.push_back(l1);
            wc_exp++;
         end
      end
      step();
   endtask

   task automatic test_reset();
      #2 reset_L = 1'b0;
      for (int i = 0; i < 3; i++) begin
         send(W'($urandom) | 9'h100, W'($urandom), 1'b0);
      end
      checks++; if (dataout0 !== 9'h000) begin errors++; $display("FAIL reset_dataout: got %h, required 000", dataout0); end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b, required 0", active); end
      checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d, required 0", word_count); end
      checks++; if ({err_order, err_strobe} !== 2'b00) begin errors++; $display("FAIL reset_errs: got %b, required 00", {err_order, err_strobe}); end
      reset_L = 1'b1;
      clear_stats();
      repeat (3) step();
      checks++; if (val_cnt != 0 || act_cnt != 0 || nz_cnt != 0) begin errors++; $display("FAIL post_reset_idle: got valid=%0d active=%0d nonzero=%0d, required 0 0 0", val_cnt, act_cnt, nz_cnt); end
      checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL post_reset_count: got %0d, required 0", word_count); end
   endtask

   task automatic test_single();
      clear_stats();
      send(9'h1AA, 9'h155, 1'b1);
      repeat (4) step();
      checks++; if (act_cnt != 2 || act_run_max != 2) begin errors++; $display("FAIL single_active: got %0d cycles, required 2", act_cnt); end
      checks++; if (val_cnt != 2 || val_run_max != 2) begin errors++; $display("FAIL single_valid: got %0d words, required 2", val_cnt); end
      checks++; if (word_count !== CW'(wc_exp)) begin errors++; $display("FAIL single_count: got %0d, required %0d", word_count, wc_exp); end
      checks++; if (dataout0 !== 9'h000) begin errors++; $display("FAIL single_idle_after: got %h, required 000", dataout0); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL single_drain: got %0d pending, required 0", exp_q.size()); end
   endtask

   task automatic test_back_to_back();
      clear_stats();
      send(9'h101, 9'h102, 1'b1); step();
      send(9'h103, 9'h104, 1'b1); step();
      send(9'h105, 9'h106, 1'b1); step();
      repeat (3) step();
      checks++; if (act_cnt != 6 || act_run_max != 6) begin errors++; $display("FAIL b2b_active: got %0d cycles run %0d, required 6 6", act_cnt, act_run_max); end
      checks++; if (val_cnt != 6 || val_run_max != 6) begin errors++; $display("FAIL b2b_gapless: got %0d words run %0d, required 6 6", val_cnt, val_run_max); end
      checks++; if (word_count !== CW'(wc_exp)) begin errors++; $display("FAIL b2b_count: got %0d, required %0d", word_count, wc_exp); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d pending, required 0", exp_q.size()); end
   endtask

   task automatic test_odd_tail();
      clear_stats();
      send(9'h1F0, 9'h0F1, 1'b1);
      repeat (3) step();
      checks++; if (val_cnt != 1 || nz_cnt != 0) begin errors++; $display("FAIL tail_output: got valid=%0d nonzero_idle=%0d, required 1 0", val_cnt, nz_cnt); end
      checks++; if (eo_cnt != 0 || es_cnt != 0) begin errors++; $display("FAIL tail_errs: got order=%0d strobe=%0d, required 0 0", eo_cnt, es_cnt); end
      checks++; if (word_count !== CW'(wc_exp)) begin errors++; $display("FAIL tail_count: got %0d, required %0d", word_count, wc_exp); end
   endtask

   task automatic test_order_violation();
      clear_stats();
      send(9'h000, 9'h1CC, 1'b0);
      repeat (3) step();
      checks++; if (eo_cnt != 1) begin errors++; $display("FAIL order_pulse: got %0d pulses, required 1", eo_cnt); end
      checks++; if (val_cnt != 0 || act_cnt != 0) begin errors++; $display("FAIL order_no_output: got valid=%0d active=%0d, required 0 0", val_cnt, act_cnt); end
      checks++; if (word_count !== CW'(wc_exp)) begin errors++; $display("FAIL order_count: got %0d, required %0d", word_count, wc_exp); end
   endtask

   task automatic test_early_strobe();
      clear_stats();
      send(9'h1A1, 9'h1A2, 1'b1);
      send(9'h1B1, 9'h1B2, 1'b0);
      repeat (3) step();
      checks++; if (es_cnt != 1 || eo_cnt != 0) begin errors++; $display("FAIL early_pulse: got strobe=%0d order=%0d, required 1 0", es_cnt, eo_cnt); end
      checks++; if (val_cnt != 2) begin errors++; $display("FAIL early_intact: got %0d words, required 2", val_cnt); end
      send(9'h1C1, 9'h1C2, 1'b1);
      repeat (3) step();
      checks++; if (val_cnt != 4 || es_cnt != 1) begin errors++; $display("FAIL early_recover: got words=%0d pulses=%0d, required 4 1", val_cnt, es_cnt); end
      checks++; if (word_count !== CW'(wc_exp)) begin errors++; $display("FAIL early_count: got %0d, required %0d", word_count, wc_exp); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL early_drain: got %0d pending, required 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid_pair();
      lane0 = 9'h1AB;
      lane1 = 9'h1CD;
      lane_strobe = 1'b1;
      exp_q.push_back(9'h1AB);
      step();
      step();
      reset_L = 1'b0;
      wc_exp = 0;
      #1;
      checks++; if (dataout0 !== 9'h000 || active !== 1'b0) begin errors++; $display("FAIL midreset_async: got data=%h active=%b, required 000 0", dataout0, active); end
      checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL midreset_count: got %0d, required 0", word_count); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL midreset_first: got %0d pending, required 0", exp_q.size()); end
      repeat (2) step();
      reset_L = 1'b1;
      clear_stats();
      repeat (4) step();
      checks++; if (val_cnt != 0 || act_cnt != 0 || nz_cnt != 0) begin errors++; $display("FAIL midreset_no_tail: got valid=%0d active=%0d nonzero=%0d, required 0 0 0", val_cnt, act_cnt, nz_cnt); end
      checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL midreset_count_after: got %0d, required 0", word_count); end
   endtask

   initial begin
      clear_stats();
      test_reset();
      test_single();
      test_back_to_back();
      test_odd_tail();
      test_order_violation();
      test_early_strobe();
      test_reset_mid_pair();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
